// File: rtl/tspp_hazard_unit_if.sv
// Hazard interface between the fetch/execute pipeline and tspp_hazard_unit.
// The hazard_unit modport consumes pipeline status and drives stall, flush and redirect controls.
interface tspp_hazard_unit_if;
  logic        i_mem_busy;
  logic        d_mem_busy;
  logic        dren;
  logic        dwen;
  logic        jump;
  logic        branch;
  logic        mispredict;
  logic        halt;
  logic [31:0] pc;
  logic        fault_insn;
  logic        mal_insn;
  logic        illegal_insn;
  logic        fault_l;
  logic        mal_l;
  logic        fault_s;
  logic        mal_s;
  logic        breakpoint;
  logic        env_m;
  logic        ret;
  logic [31:0] epc_f;
  logic [31:0] epc_e;
  logic [31:0] badaddr_f;
  logic [31:0] badaddr_e;
  logic        token_ex;

  logic        pc_en;
  logic        npc_sel;
  logic        if_ex_stall;
  logic        if_ex_flush;
  logic [31:0] priv_pc;
  logic        insert_priv_pc;
  logic        iren;

  modport hazard_unit (
    input  i_mem_busy, d_mem_busy, dren, dwen, jump, branch, mispredict, halt, pc,
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
    input  breakpoint, env_m, ret, epc_f, epc_e, badaddr_f, badaddr_e, token_ex,
    output pc_en, npc_sel, if_ex_stall, if_ex_flush, priv_pc, insert_priv_pc, iren
  );
endinterface

// File: rtl/tspp_hazard_unit.sv
// Hazard and trap sequencer for the two-stage pipeline: stalls, flushes, redirects, trap/mret insertion.
// Optional feature: define TSPP_HAZARD_MTVAL_EN to capture the bad address into mtval_o.
module tspp_hazard_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic                       CLK,
  input  logic                       RST,
  tspp_hazard_unit_if.hazard_unit    hazard_if,
  input  logic [31:0]                mtvec,
  input  logic [31:0]                mepc,
  output logic                       trap_o,
  output logic [3:0]                 cause_o,
  output logic [31:0]                epc_o,
  output logic [31:0]                mtval_o
);

  typedef enum logic [1:0] {RUN, WAIT, INSERT, HALTED} state_t;

  state_t      state_reg;
  logic [31:0] priv_pc_reg;
  logic [3:0]  cause_reg;
  logic [31:0] epc_reg;
  logic        is_trap_reg;
  logic        insert_reg;
  logic        trap_reg;

  logic        exc;
  logic        ret_v;
  logic        mem_busy;
  logic        fetch_cause;
  logic [3:0]  cause_next;
  logic [31:0] epc_next;
  logic        stall_run;
  logic        npc_run;

  assign exc = (hazard_if.breakpoint | hazard_if.mal_insn | hazard_if.fault_insn |
                hazard_if.illegal_insn | hazard_if.env_m | hazard_if.mal_l |
                hazard_if.fault_l | hazard_if.mal_s | hazard_if.fault_s) & hazard_if.token_ex;
  assign ret_v    = hazard_if.ret & hazard_if.token_ex;
  assign mem_busy = hazard_if.i_mem_busy | hazard_if.d_mem_busy;

  // Priority encoder: breakpoint outranks fetch faults, which outrank execute faults.
  always_comb begin
    cause_next  = 4'd7;
    fetch_cause = 1'b0;
    if (hazard_if.breakpoint) begin
      cause_next = 4'd3;
    end else if (hazard_if.mal_insn) begin
      cause_next  = 4'd0;
      fetch_cause = 1'b1;
    end else if (hazard_if.fault_insn) begin
      cause_next  = 4'd1;
      fetch_cause = 1'b1;
    end else if (hazard_if.illegal_insn) begin
      cause_next = 4'd2;
    end else if (hazard_if.env_m) begin
      cause_next = 4'd11;
    end else if (hazard_if.mal_l) begin
      cause_next = 4'd4;
    end else if (hazard_if.fault_l) begin
      cause_next = 4'd5;
    end else if (hazard_if.mal_s) begin
      cause_next = 4'd6;
    end
  end

  assign epc_next = fetch_cause ? hazard_if.epc_f : hazard_if.epc_e;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= RUN;
      priv_pc_reg <= RESET_PC;
      cause_reg   <= 4'd0;
      epc_reg     <= RESET_PC;
      is_trap_reg <= 1'b0;
      insert_reg  <= 1'b0;
      trap_reg    <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          insert_reg <= 1'b0;
          trap_reg   <= 1'b0;
          if (exc || ret_v) begin
            // A trap always wins over a simultaneous mret.
            priv_pc_reg <= exc ? mtvec : mepc;
            is_trap_reg <= exc;
            if (exc) begin
              cause_reg <= cause_next;
              epc_reg   <= epc_next;
            end
            if (mem_busy) begin
              state_reg <= WAIT;
            end else begin
              state_reg  <= INSERT;
              insert_reg <= 1'b1;
              trap_reg   <= exc;
            end
          end else if (hazard_if.halt) begin
            state_reg <= HALTED;
          end
        end
        WAIT: begin
          if (!mem_busy) begin
            state_reg  <= INSERT;
            insert_reg <= 1'b1;
            trap_reg   <= is_trap_reg;
          end
        end
        INSERT: begin
          state_reg  <= RUN;
          insert_reg <= 1'b0;
          trap_reg   <= 1'b0;
        end
        default: begin
          state_reg <= HALTED;
        end
      endcase
    end
  end

`ifdef TSPP_HAZARD_MTVAL_EN
  logic [31:0] mtval_reg;
  logic [31:0] mtval_next;

  always_comb begin
    if (cause_next == 4'd2 || cause_next == 4'd3 || cause_next == 4'd11) begin
      mtval_next = 32'd0;
    end else begin
      mtval_next = fetch_cause ? hazard_if.badaddr_f : hazard_if.badaddr_e;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mtval_reg <= 32'd0;
    end else if (state_reg == RUN && exc) begin
      mtval_reg <= mtval_next;
    end
  end

  assign mtval_o = mtval_reg;
`else
  assign mtval_o = 32'd0;
`endif

  assign stall_run = (hazard_if.d_mem_busy & (hazard_if.dren | hazard_if.dwen)) | hazard_if.i_mem_busy;
  assign npc_run   = hazard_if.jump | (hazard_if.branch & hazard_if.mispredict);

  always_comb begin
    hazard_if.if_ex_stall = stall_run;
    hazard_if.npc_sel     = npc_run;
    hazard_if.pc_en       = (~stall_run | npc_run) & ~hazard_if.i_mem_busy;
    hazard_if.if_ex_flush = npc_run & ~stall_run;
    hazard_if.iren        = 1'b1;
    case (state_reg)
      WAIT: begin
        hazard_if.if_ex_stall = 1'b1;
        hazard_if.npc_sel     = 1'b0;
        hazard_if.pc_en       = 1'b0;
        hazard_if.if_ex_flush = 1'b0;
      end
      INSERT: begin
        hazard_if.if_ex_stall = 1'b0;
        hazard_if.npc_sel     = 1'b0;
        hazard_if.pc_en       = 1'b1;
        hazard_if.if_ex_flush = 1'b1;
      end
      HALTED: begin
        hazard_if.if_ex_stall = 1'b1;
        hazard_if.npc_sel     = 1'b0;
        hazard_if.pc_en       = 1'b0;
        hazard_if.if_ex_flush = 1'b0;
        hazard_if.iren        = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign hazard_if.priv_pc        = priv_pc_reg;
  assign hazard_if.insert_priv_pc = insert_reg;
  assign trap_o                   = trap_reg;
  assign cause_o                  = cause_reg;
  assign epc_o                    = epc_reg;

endmodule

// File: tb/tb_tspp_hazard_unit.sv
// Self-checking bench for tspp_hazard_unit: trap/mret events go through a scoreboard queue
// and are compared when the DUT raises insert_priv_pc.
module tb_tspp_hazard_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0200;
`ifdef TSPP_HAZARD_MTVAL_EN
  localparam bit MTVAL_EN = 1'b1;
`else
  localparam bit MTVAL_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] mtvec = 32'd0;
  logic [31:0] mepc = 32'd0;
  logic        trap_o;
  logic [3:0]  cause_o;
  logic [31:0] epc_o;
  logic [31:0] mtval_o;

  tspp_hazard_unit_if hif ();

  tspp_hazard_unit #(.RESET_PC(RESET_PC)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .hazard_if (hif),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .trap_o    (trap_o),
    .cause_o   (cause_o),
    .epc_o     (epc_o),
    .mtval_o   (mtval_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] priv_pc;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] epc;
    logic [31:0] mtval;
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  m_cause = 4'd0;
  logic [31:0] m_epc = RESET_PC;
  logic [31:0] m_mtval = 32'd0;

  function automatic string ev_str(input ev_t e);
    return $sformatf("pc=%h trap=%0b cause=%0d epc=%h mtval=%h", e.priv_pc, e.trap, e.cause, e.epc, e.mtval);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    hif.i_mem_busy = 0; hif.d_mem_busy = 0; hif.dren = 0; hif.dwen = 0;
    hif.jump = 0; hif.branch = 0; hif.mispredict = 0; hif.halt = 0; hif.pc = 32'd0;
    hif.fault_insn = 0; hif.mal_insn = 0; hif.illegal_insn = 0; hif.fault_l = 0;
    hif.mal_l = 0; hif.fault_s = 0; hif.mal_s = 0; hif.breakpoint = 0; hif.env_m = 0;
    hif.ret = 0; hif.token_ex = 0;
    hif.epc_f = 32'd0; hif.epc_e = 32'd0; hif.badaddr_f = 32'd0; hif.badaddr_e = 32'd0;
  endtask

  task automatic model_reset();
    m_cause = 4'd0; m_epc = RESET_PC; m_mtval = 32'd0;
  endtask

  task automatic push_trap(input logic [31:0] tgt, input logic [3:0] c, input logic [31:0] e,
                           input logic [31:0] mv);
    ev_t x;
    m_cause = c; m_epc = e; m_mtval = MTVAL_EN ? mv : 32'd0;
    x.priv_pc = tgt; x.trap = 1'b1; x.cause = m_cause; x.epc = m_epc; x.mtval = m_mtval;
    sb.push_back(x);
  endtask

  task automatic push_ret(input logic [31:0] tgt);
    ev_t x;
    x.priv_pc = tgt; x.trap = 1'b0; x.cause = m_cause; x.epc = m_epc; x.mtval = m_mtval;
    sb.push_back(x);
  endtask

  function automatic ev_t observe();
    ev_t o;
    o.priv_pc = hif.priv_pc; o.trap = trap_o; o.cause = cause_o; o.epc = epc_o; o.mtval = mtval_o;
    return o;
  endfunction

  task automatic wait_insert(input int max_cycles, output int waited, output bit seen);
    waited = 0;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (hif.insert_priv_pc === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
      waited++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    step(); step();
    RST = 1'b0;
    model_reset();
    #1;
    n_checks++; if (hif.priv_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_priv_pc: got %h, required %h", hif.priv_pc, RESET_PC); end
    n_checks++; if (epc_o !== RESET_PC) begin n_fail++; $display("FAIL reset_epc: got %h, required %h", epc_o, RESET_PC); end
    n_checks++; if (cause_o !== 4'd0) begin n_fail++; $display("FAIL reset_cause: got %0d, required 0", cause_o); end
    n_checks++; if (mtval_o !== 32'd0) begin n_fail++; $display("FAIL reset_mtval: got %h, required 0", mtval_o); end
    n_checks++; if (trap_o !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b, required 0", trap_o); end
    n_checks++; if (hif.insert_priv_pc !== 1'b0) begin n_fail++; $display("FAIL reset_insert: got %b, required 0", hif.insert_priv_pc); end
    n_checks++;
    if ({hif.iren, hif.pc_en, hif.if_ex_stall, hif.if_ex_flush, hif.npc_sel} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_run_outputs: got iren/pc_en/stall/flush/npc=%b, required 11000",
               {hif.iren, hif.pc_en, hif.if_ex_stall, hif.if_ex_flush, hif.npc_sel});
    end
  endtask

  task automatic test_trap_idle();
    int waited; bit seen; ev_t e; ev_t o;
    hif.illegal_insn = 1; hif.token_ex = 1; hif.epc_e = 32'h100; hif.badaddr_e = 32'hdead;
    mtvec = 32'h800;
    push_trap(32'h800, 4'd2, 32'h100, 32'd0);
    step();
    clear_inputs();
    wait_insert(20, waited, seen);
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL trap_idle_timeout: no insert_priv_pc within 20 cycles, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL trap_idle_event: got %s, required %s", ev_str(o), ev_str(e)); end
    n_checks++; if (waited != 0) begin n_fail++; $display("FAIL trap_idle_latency: got %0d extra cycles, required 0", waited); end
    n_checks++;
    if ({hif.pc_en, hif.if_ex_flush} !== 2'b11) begin
      n_fail++; $display("FAIL trap_idle_insert_ctl: got pc_en/flush=%b, required 11", {hif.pc_en, hif.if_ex_flush});
    end
    step();
    n_checks++;
    if ({hif.insert_priv_pc, trap_o} !== 2'b00) begin
      n_fail++; $display("FAIL trap_idle_one_cycle: got insert/trap=%b, required 00", {hif.insert_priv_pc, trap_o});
    end
  endtask

  task automatic test_trap_busy();
    int wait_cnt; bit seen; ev_t e; ev_t o;
    hif.fault_l = 1; hif.token_ex = 1; hif.d_mem_busy = 1;
    hif.epc_e = 32'h3000; hif.badaddr_e = 32'h2004; mtvec = 32'h880;
    push_trap(32'h880, 4'd5, 32'h3000, 32'h2004);
    step();
    hif.fault_l = 0; hif.token_ex = 0;
    wait_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (hif.insert_priv_pc === 1'b1) begin seen = 1'b1; break; end
      if (i == 2) hif.d_mem_busy = 0;
      #1;
      if (hif.pc_en === 1'b0 && hif.if_ex_stall === 1'b1) wait_cnt++;
      step();
    end
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL trap_busy_timeout: no insert_priv_pc within 20 cycles, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL trap_busy_event: got %s, required %s", ev_str(o), ev_str(e)); end
    n_checks++; if (wait_cnt != 3) begin n_fail++; $display("FAIL trap_busy_wait_cycles: got %0d, required 3", wait_cnt); end
    step();
    clear_inputs();
  endtask

  task automatic test_ret();
    int waited; bit seen; ev_t e; ev_t o;
    hif.ret = 1; hif.token_ex = 1; mepc = 32'h444;
    push_ret(32'h444);
    step();
    clear_inputs();
    wait_insert(20, waited, seen);
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ret_timeout: no insert_priv_pc within 20 cycles, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL ret_event: got %s, required %s", ev_str(o), ev_str(e)); end
    n_checks++; if (hif.if_ex_flush !== 1'b1) begin n_fail++; $display("FAIL ret_flush: got %b, required 1", hif.if_ex_flush); end
    step();
  endtask

  task automatic test_priority();
    int waited; bit seen; ev_t e; ev_t o;
    hif.ret = 1; hif.mal_s = 1; hif.token_ex = 1; mepc = 32'h444; mtvec = 32'h900;
    hif.epc_e = 32'h120; hif.badaddr_e = 32'h5556;
    push_trap(32'h900, 4'd6, 32'h120, 32'h5556);
    step();
    clear_inputs();
    wait_insert(20, waited, seen);
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL prio_ret_mal_s_timeout: no insert, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL prio_ret_mal_s: got %s, required %s", ev_str(o), ev_str(e)); end
    step();
    hif.breakpoint = 1; hif.fault_insn = 1; hif.token_ex = 1;
    hif.epc_f = 32'h140; hif.badaddr_f = 32'h77; hif.epc_e = 32'h160; hif.badaddr_e = 32'h99;
    push_trap(32'h900, 4'd3, 32'h160, 32'd0);
    step();
    clear_inputs();
    wait_insert(20, waited, seen);
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL prio_bkpt_fault_timeout: no insert, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL prio_bkpt_fault: got %s, required %s", ev_str(o), ev_str(e)); end
    step();
  endtask

  task automatic test_no_token();
    int waited; bit seen;
    hif.illegal_insn = 1; hif.ret = 1; hif.token_ex = 0; mtvec = 32'hA00;
    step(); step();
    clear_inputs();
    wait_insert(3, waited, seen);
    n_checks++; if (seen) begin n_fail++; $display("FAIL no_token_insert: got insert_priv_pc=1, required 0"); end
  endtask

  task automatic test_branch();
    hif.branch = 1; hif.mispredict = 1;
    #1;
    n_checks++;
    if ({hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall} !== 4'b1110) begin
      n_fail++; $display("FAIL branch_idle: got npc/flush/pc_en/stall=%b, required 1110",
                         {hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall});
    end
    hif.dren = 1; hif.d_mem_busy = 1;
    #1;
    n_checks++;
    if ({hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall} !== 4'b1011) begin
      n_fail++; $display("FAIL branch_dbusy: got npc/flush/pc_en/stall=%b, required 1011",
                         {hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall});
    end
    hif.branch = 0; hif.jump = 1; hif.i_mem_busy = 1;
    #1;
    n_checks++;
    if ({hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall} !== 4'b1001) begin
      n_fail++; $display("FAIL jump_ibusy: got npc/flush/pc_en/stall=%b, required 1001",
                         {hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall});
    end
    clear_inputs();
    hif.branch = 1; hif.mispredict = 0; hif.dwen = 1;
    #1;
    n_checks++;
    if ({hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall} !== 4'b0010) begin
      n_fail++; $display("FAIL branch_predicted: got npc/flush/pc_en/stall=%b, required 0010",
                         {hif.npc_sel, hif.if_ex_flush, hif.pc_en, hif.if_ex_stall});
    end
    clear_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int waited; bit seen; ev_t e; ev_t o;
    hif.mal_insn = 1; hif.token_ex = 1; mtvec = 32'hB00;
    hif.epc_f = 32'h1f0; hif.badaddr_f = 32'h1f2; hif.epc_e = 32'h1ec; hif.badaddr_e = 32'h3;
    push_trap(32'hB00, 4'd0, 32'h1f0, 32'h1f2);
    step();
    clear_inputs();
    wait_insert(20, waited, seen);
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_first_timeout: no insert, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL b2b_first: got %s, required %s", ev_str(o), ev_str(e)); end
    step();
    hif.env_m = 1; hif.token_ex = 1; mtvec = 32'hC00; hif.epc_e = 32'h2a0; hif.badaddr_e = 32'h55;
    push_trap(32'hC00, 4'd11, 32'h2a0, 32'd0);
    step();
    clear_inputs();
    wait_insert(20, waited, seen);
    e = sb.pop_front(); o = observe();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_second_timeout: no insert, required %s", ev_str(e)); end
    else if (o !== e) begin n_fail++; $display("FAIL b2b_second: got %s, required %s", ev_str(o), ev_str(e)); end
    n_checks++; if (waited != 0) begin n_fail++; $display("FAIL b2b_second_latency: got %0d extra cycles, required 0", waited); end
    step();
  endtask

  task automatic test_halt();
    int bad = 0;
    hif.halt = 1;
    step();
    clear_inputs();
    hif.jump = 1; hif.illegal_insn = 1; hif.token_ex = 1;
    for (int i = 0; i < 12; i++) begin
      if ({hif.iren, hif.pc_en, hif.if_ex_stall, hif.insert_priv_pc} !== 4'b0010) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL halt_sticky: got %0d bad cycles of 12, required 0", bad); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    n_checks++;
    if ({hif.priv_pc, hif.iren, hif.pc_en} !== {RESET_PC, 2'b11}) begin
      n_fail++; $display("FAIL halt_reset: got priv_pc=%h iren=%b pc_en=%b, required %h 1 1",
                         hif.priv_pc, hif.iren, hif.pc_en, RESET_PC);
    end
  endtask

  task automatic test_reset_in_wait();
    int waited; bit seen;
    hif.illegal_insn = 1; hif.token_ex = 1; hif.i_mem_busy = 1; mtvec = 32'hD00; hif.epc_e = 32'h3c;
    step();
    clear_inputs();
    hif.i_mem_busy = 1;
    RST = 1'b1;
    step();
    RST = 1'b0;
    hif.i_mem_busy = 0;
    model_reset();
    n_checks++;
    if ({hif.insert_priv_pc, trap_o, hif.priv_pc, cause_o, epc_o} !== {2'b00, RESET_PC, 4'd0, RESET_PC}) begin
      n_fail++; $display("FAIL rst_wait_values: got insert=%b trap=%b pc=%h cause=%0d epc=%h, required 0 0 %h 0 %h",
                         hif.insert_priv_pc, trap_o, hif.priv_pc, cause_o, epc_o, RESET_PC, RESET_PC);
    end
    wait_insert(4, waited, seen);
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_wait_no_insert: got insert_priv_pc=1, required 0"); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_trap_idle();
    test_trap_busy();
    test_ret();
    test_priority();
    test_no_token();
    test_branch();
    test_back_to_back();
    test_halt();
    test_reset_in_wait();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
